// File: rtl/tank_game_pkg.sv
// Shared constants and types for the artillery game turn controller.
//   state_t   : turn-sequencing states, encoded as seen on the phase output
//   KEY_*     : USB keycodes the scheduler reacts to
//   WIN_*     : winner output encoding
//   sat_sub   : HP subtraction that floors at zero
package tank_game_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        AIM    = 3'd1,
        FLIGHT = 3'd2,
        SETTLE = 3'd3,
        OVER   = 3'd4
    } state_t;

    localparam logic [7:0] KEY_ENTER = 8'h28;
    localparam logic [7:0] KEY_SPACE = 8'h2C;

    localparam logic [1:0] WIN_NONE = 2'd0;
    localparam logic [1:0] WIN_A    = 2'd1;
    localparam logic [1:0] WIN_B    = 2'd2;
    localparam logic [1:0] WIN_DRAW = 2'd3;

    // Damage larger than the remaining HP leaves the tank at 0 rather than
    // wrapping around to a large value.
    function automatic logic [3:0] sat_sub(input logic [3:0] hp, input logic [3:0] dmg);
        return (hp > dmg) ? (hp - dmg) : 4'd0;
    endfunction

endpackage

// File: rtl/turn_scheduler_if.sv
// Signal bundle between the turn scheduler and its neighbours.
//   master : keyboard decoder / projectile side (drives keycode, shot_done,
//            hit_A, hit_B; observes everything else)
//   slave  : the turn scheduler itself
interface turn_scheduler_if;
    logic [7:0] keycode;
    logic       shot_done;
    logic       hit_A;
    logic       hit_B;
    logic [7:0] keycode_A;
    logic [7:0] keycode_B;
    logic       turn;
    logic       fire_req;
    logic [3:0] HP_A;
    logic [3:0] HP_B;
    logic [2:0] phase;
    logic [9:0] timer;
    logic [1:0] winner;

    modport master (
        output keycode, shot_done, hit_A, hit_B,
        input  keycode_A, keycode_B, turn, fire_req, HP_A, HP_B, phase, timer, winner
    );

    modport slave (
        input  keycode, shot_done, hit_A, hit_B,
        output keycode_A, keycode_B, turn, fire_req, HP_A, HP_B, phase, timer, winner
    );
endinterface

// File: rtl/frame_timer.sv
// Loadable 10-bit frame down-counter, shared by the timed states.
//   frame_clk : frame clock
//   Reset     : synchronous active-low reset, clears the count
//   load      : load value on this edge (overrides counting)
//   value     : load value
//   count     : current count
//   zero      : count is 0
// Counts down by one per frame and holds at 0 until reloaded.
module frame_timer (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic       load,
    input  logic [9:0] value,
    output logic [9:0] count,
    output logic       zero
);
    logic [9:0] count_reg;

    always_ff @(posedge frame_clk) begin
        if (!Reset) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= value;
        end else if (count_reg != 10'd0) begin
            count_reg <= count_reg - 10'd1;
        end
    end

    assign count = count_reg;
    assign zero  = (count_reg == 10'd0);
endmodule

// File: rtl/turn_scheduler.sv
// Two-player turn controller for the artillery game.
//   frame_clk : frame clock (one edge per video frame)
//   Reset     : synchronous active-low reset
//   bus       : turn_scheduler_if.slave
//       in  keycode, shot_done, hit_A, hit_B
//       out keycode_A/B (gated keycodes), turn, fire_req, HP_A/B, phase,
//           timer, winner
// Routes the keycode to the active tank, sequences aim / flight / settle,
// applies hit damage and declares the winner. All outputs are registered.
module turn_scheduler
    import tank_game_pkg::*;
#(
    parameter int HP_INIT       = 10,
    parameter int DAMAGE        = 3,
    parameter int TURN_FRAMES   = 600,
    parameter int FLIGHT_MAX    = 240,
    parameter int SETTLE_FRAMES = 30
) (
    input  logic             frame_clk,
    input  logic             Reset,
    turn_scheduler_if.slave  bus
);
    localparam logic [3:0] HP_START    = 4'(HP_INIT);
    localparam logic [3:0] DMG         = 4'(DAMAGE);
    localparam logic [9:0] AIM_LOAD    = 10'(TURN_FRAMES - 1);
    localparam logic [9:0] FLIGHT_LOAD = 10'(FLIGHT_MAX - 1);
    localparam logic [9:0] SETTLE_LOAD = 10'(SETTLE_FRAMES - 1);

    state_t     state_reg, state_next;
    logic       turn_reg, turn_next;
    logic [3:0] hp_a_reg, hp_a_next;
    logic [3:0] hp_b_reg, hp_b_next;
    logic [1:0] winner_reg, winner_next;
    logic       fire_reg, fire_next;
    logic [7:0] key_prev_reg;
    logic [7:0] key_a_reg, key_a_next;
    logic [7:0] key_b_reg, key_b_next;

    logic       timer_load;
    logic [9:0] timer_value;
    logic [9:0] timer_count;
    logic       timer_zero;
    logic       space_edge;

    frame_timer u_timer (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .load      (timer_load),
        .value     (timer_value),
        .count     (timer_count),
        .zero      (timer_zero)
    );

    // A held space bar only fires once: require a non-space previous frame.
    assign space_edge = (bus.keycode == KEY_SPACE) && (key_prev_reg != KEY_SPACE);

    always_comb begin
        state_next  = state_reg;
        turn_next   = turn_reg;
        hp_a_next   = hp_a_reg;
        hp_b_next   = hp_b_reg;
        winner_next = winner_reg;
        fire_next   = 1'b0;
        timer_load  = 1'b0;
        timer_value = '0;

        case (state_reg)
            IDLE: begin
                if (bus.keycode == KEY_ENTER) begin
                    state_next  = AIM;
                    timer_load  = 1'b1;
                    timer_value = AIM_LOAD;
                end
            end
            AIM: begin
                // Firing takes precedence over running out of time on the same frame.
                if (space_edge) begin
                    state_next  = FLIGHT;
                    fire_next   = 1'b1;
                    timer_load  = 1'b1;
                    timer_value = FLIGHT_LOAD;
                end else if (timer_zero) begin
                    state_next  = SETTLE;
                    timer_load  = 1'b1;
                    timer_value = SETTLE_LOAD;
                end
            end
            FLIGHT: begin
                if (bus.shot_done) begin
                    if (bus.hit_A) hp_a_next = sat_sub(hp_a_reg, DMG);
                    if (bus.hit_B) hp_b_next = sat_sub(hp_b_reg, DMG);
                    state_next  = SETTLE;
                    timer_load  = 1'b1;
                    timer_value = SETTLE_LOAD;
                end else if (timer_zero) begin
                    state_next  = SETTLE;
                    timer_load  = 1'b1;
                    timer_value = SETTLE_LOAD;
                end
            end
            SETTLE: begin
                if (timer_zero) begin
                    if (hp_a_reg == 4'd0 && hp_b_reg == 4'd0) begin
                        winner_next = WIN_DRAW;
                        state_next  = OVER;
                    end else if (hp_b_reg == 4'd0) begin
                        winner_next = WIN_A;
                        state_next  = OVER;
                    end else if (hp_a_reg == 4'd0) begin
                        winner_next = WIN_B;
                        state_next  = OVER;
                    end else begin
                        turn_next   = ~turn_reg;
                        state_next  = AIM;
                        timer_load  = 1'b1;
                        timer_value = AIM_LOAD;
                    end
                end
            end
            OVER: begin
                if (bus.keycode == KEY_ENTER) begin
                    hp_a_next   = HP_START;
                    hp_b_next   = HP_START;
                    turn_next   = 1'b0;
                    winner_next = WIN_NONE;
                    state_next  = AIM;
                    timer_load  = 1'b1;
                    timer_value = AIM_LOAD;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Gating follows the next state and turn so that a turn switch shows
        // up on turn and on the gated keycodes in the same cycle.
        key_a_next = (state_next == AIM && !turn_next) ? bus.keycode : 8'h00;
        key_b_next = (state_next == AIM &&  turn_next) ? bus.keycode : 8'h00;
    end

    always_ff @(posedge frame_clk) begin
        if (!Reset) begin
            state_reg    <= IDLE;
            turn_reg     <= 1'b0;
            hp_a_reg     <= HP_START;
            hp_b_reg     <= HP_START;
            winner_reg   <= WIN_NONE;
            fire_reg     <= 1'b0;
            key_prev_reg <= 8'h00;
            key_a_reg    <= 8'h00;
            key_b_reg    <= 8'h00;
        end else begin
            state_reg    <= state_next;
            turn_reg     <= turn_next;
            hp_a_reg     <= hp_a_next;
            hp_b_reg     <= hp_b_next;
            winner_reg   <= winner_next;
            fire_reg     <= fire_next;
            key_prev_reg <= bus.keycode;
            key_a_reg    <= key_a_next;
            key_b_reg    <= key_b_next;
        end
    end

    assign bus.keycode_A = key_a_reg;
    assign bus.keycode_B = key_b_reg;
    assign bus.turn      = turn_reg;
    assign bus.fire_req  = fire_reg;
    assign bus.HP_A      = hp_a_reg;
    assign bus.HP_B      = hp_b_reg;
    assign bus.phase     = state_reg;
    assign bus.timer     = timer_count;
    assign bus.winner    = winner_reg;
endmodule

// File: tb/tb_turn_scheduler.sv
// Self-checking bench for turn_scheduler: directed game scenarios followed by
// randomized play, all checked every cycle against a behavioural game model.
module tb_turn_scheduler;
    localparam int HP_INIT       = 10;
    localparam int DAMAGE        = 3;
    localparam int TURN_FRAMES   = 600;
    localparam int FLIGHT_MAX    = 240;
    localparam int SETTLE_FRAMES = 30;
    localparam int K_ENTER       = 8'h28;
    localparam int K_SPACE       = 8'h2C;

    logic frame_clk = 1'b0;
    logic Reset     = 1'b0;
    always #5 frame_clk = ~frame_clk;

    turn_scheduler_if bus();

    turn_scheduler #(
        .HP_INIT       (HP_INIT),
        .DAMAGE        (DAMAGE),
        .TURN_FRAMES   (TURN_FRAMES),
        .FLIGHT_MAX    (FLIGHT_MAX),
        .SETTLE_FRAMES (SETTLE_FRAMES)
    ) dut (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .bus       (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    bit check_en    = 1'b0;

    // Game model: phase 0 idle, 1 aim, 2 flight, 3 settle, 4 over.
    int m_phase = 0, m_turn = 0, m_hpa = HP_INIT, m_hpb = HP_INIT, m_win = 0;
    int m_timer = 0, m_prev = 0, m_ka = 0, m_kb = 0, m_fire = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Literal expectation pinned on both the DUT and the model.
    task automatic pin(input string name, input logic [31:0] act, input int model_val, input int lit);
        chk({name, " dut"}, act, lit);
        chk({name, " model"}, model_val, lit);
    endtask

    function automatic int hp_after_hit(input int hp);
        return (hp > DAMAGE) ? hp - DAMAGE : 0;
    endfunction

    task automatic model_step();
        int key;
        key = int'(bus.keycode);
        if (Reset === 1'b0) begin
            m_phase = 0; m_turn = 0; m_hpa = HP_INIT; m_hpb = HP_INIT; m_win = 0;
            m_timer = 0; m_prev = 0; m_ka = 0; m_kb = 0; m_fire = 0;
        end else begin
            m_fire = 0;
            case (m_phase)
                0: if (key == K_ENTER) begin m_phase = 1; m_timer = TURN_FRAMES - 1; end
                1: begin
                    if (key == K_SPACE && m_prev != K_SPACE) begin
                        m_phase = 2; m_timer = FLIGHT_MAX - 1; m_fire = 1;
                    end else if (m_timer == 0) begin
                        m_phase = 3; m_timer = SETTLE_FRAMES - 1;
                    end else m_timer--;
                end
                2: begin
                    if (bus.shot_done === 1'b1) begin
                        if (bus.hit_A === 1'b1) m_hpa = hp_after_hit(m_hpa);
                        if (bus.hit_B === 1'b1) m_hpb = hp_after_hit(m_hpb);
                        m_phase = 3; m_timer = SETTLE_FRAMES - 1;
                    end else if (m_timer == 0) begin
                        m_phase = 3; m_timer = SETTLE_FRAMES - 1;
                    end else m_timer--;
                end
                3: begin
                    if (m_timer == 0) begin
                        if (m_hpa == 0 && m_hpb == 0) begin m_win = 3; m_phase = 4; end
                        else if (m_hpb == 0)          begin m_win = 1; m_phase = 4; end
                        else if (m_hpa == 0)          begin m_win = 2; m_phase = 4; end
                        else begin m_turn = 1 - m_turn; m_phase = 1; m_timer = TURN_FRAMES - 1; end
                    end else m_timer--;
                end
                default: if (key == K_ENTER) begin
                    m_hpa = HP_INIT; m_hpb = HP_INIT; m_turn = 0; m_win = 0;
                    m_phase = 1; m_timer = TURN_FRAMES - 1;
                end
            endcase
            m_prev = key;
            m_ka = (m_phase == 1 && m_turn == 0) ? key : 0;
            m_kb = (m_phase == 1 && m_turn == 1) ? key : 0;
        end
    endtask

    initial forever begin
        @(posedge frame_clk);
        model_step();
    end

    // Per-cycle comparison, away from the active edge.
    initial forever begin
        @(negedge frame_clk);
        if (check_en) begin
            chk("phase",     bus.phase,     m_phase);
            chk("turn",      bus.turn,      m_turn);
            chk("fire_req",  bus.fire_req,  m_fire);
            chk("HP_A",      bus.HP_A,      m_hpa);
            chk("HP_B",      bus.HP_B,      m_hpb);
            chk("timer",     bus.timer,     m_timer);
            chk("winner",    bus.winner,    m_win);
            chk("keycode_A", bus.keycode_A, m_ka);
            chk("keycode_B", bus.keycode_B, m_kb);
        end
    end

    task automatic cycle(input logic rst, input logic [7:0] key, input logic sd,
                         input logic ha, input logic hb);
        Reset         = rst;
        bus.keycode   = key;
        bus.shot_done = sd;
        bus.hit_A     = ha;
        bus.hit_B     = hb;
        @(posedge frame_clk);
        @(negedge frame_clk);
    endtask

    // From AIM: release, fire, fly a few frames, land with the given hits.
    task automatic play_shot(input logic ha, input logic hb);
        cycle(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'h2C, 1'b0, 1'b0, 1'b0);
        repeat (3) cycle(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'h00, 1'b1, ha, hb);
    endtask

    task automatic settle();
        repeat (SETTLE_FRAMES) cycle(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int fires;
        logic [7:0] rkey;
        int r;

        // Reset
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        check_en = 1'b1;
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        pin("reset phase",  bus.phase,     m_phase, 0);
        pin("reset HP_A",   bus.HP_A,      m_hpa,   10);
        pin("reset HP_B",   bus.HP_B,      m_hpb,   10);
        pin("reset timer",  bus.timer,     m_timer, 0);
        pin("reset winner", bus.winner,    m_win,   0);

        // Enter, then a keypress routed to A only
        cycle(1'b1, 8'h28, 1'b0, 1'b0, 1'b0);
        pin("enter phase", bus.phase, m_phase, 1);
        pin("enter timer", bus.timer, m_timer, 599);
        repeat (3) cycle(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'h07, 1'b0, 1'b0, 1'b0);
        pin("aim keycode_A", bus.keycode_A, m_ka, 7);
        pin("aim keycode_B", bus.keycode_B, m_kb, 0);

        // Space edge fires once; held space does not refire
        cycle(1'b1, 8'h2C, 1'b0, 1'b0, 1'b0);
        pin("fire pulse",   bus.fire_req, m_fire,  1);
        pin("flight phase", bus.phase,    m_phase, 2);
        pin("flight timer", bus.timer,    m_timer, 239);
        fires = 0;
        repeat (10) begin
            cycle(1'b1, 8'h2C, 1'b0, 1'b0, 1'b0);
            if (bus.fire_req === 1'b1) fires++;
        end
        chk("held space refire count", fires, 0);

        // Hit on B, then turn passes to B after settle
        repeat (5) cycle(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'h00, 1'b1, 1'b0, 1'b1);
        pin("hit B HP_B",   bus.HP_B,  m_hpb,   7);
        pin("hit B HP_A",   bus.HP_A,  m_hpa,   10);
        pin("settle phase", bus.phase, m_phase, 3);
        pin("settle timer", bus.timer, m_timer, 29);
        repeat (29) cycle(1'b1, 8'h07, 1'b0, 1'b0, 1'b0);
        pin("turn before switch", bus.turn, m_turn, 0);
        cycle(1'b1, 8'h07, 1'b0, 1'b0, 1'b0);
        pin("turn after switch", bus.turn,      m_turn, 1);
        pin("B keycode_B",       bus.keycode_B, m_kb,   7);
        pin("B keycode_A",       bus.keycode_A, m_ka,   0);

        // Wear A down to 1, then a final hit saturates at 0
        repeat (3) begin play_shot(1'b1, 1'b0); settle(); end
        pin("HP_A worn", bus.HP_A, m_hpa, 1);
        play_shot(1'b1, 1'b0);
        pin("HP_A saturate", bus.HP_A, m_hpa, 0);
        repeat (SETTLE_FRAMES - 1) cycle(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        pin("still settling", bus.phase, m_phase, 3);
        cycle(1'b1, 8'h07, 1'b0, 1'b0, 1'b0);
        pin("B wins phase",  bus.phase,     m_phase, 4);
        pin("B wins winner", bus.winner,    m_win,   2);
        pin("over keycode_A", bus.keycode_A, m_ka,   0);

        // Restart from OVER
        cycle(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'h28, 1'b0, 1'b0, 1'b0);
        pin("restart HP_A",   bus.HP_A,   m_hpa,   10);
        pin("restart HP_B",   bus.HP_B,   m_hpb,   10);
        pin("restart turn",   bus.turn,   m_turn,  0);
        pin("restart winner", bus.winner, m_win,   0);
        pin("restart phase",  bus.phase,  m_phase, 1);

        // Mutual hits down to a draw
        repeat (3) begin play_shot(1'b1, 1'b1); settle(); end
        pin("draw pre HP_A", bus.HP_A, m_hpa, 1);
        pin("draw pre HP_B", bus.HP_B, m_hpb, 1);
        play_shot(1'b1, 1'b1);
        settle();
        pin("draw winner", bus.winner, m_win,   3);
        pin("draw phase",  bus.phase,  m_phase, 4);
        cycle(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'h28, 1'b0, 1'b0, 1'b0);

        // Forfeit after the full aim budget
        fires = 0;
        repeat (TURN_FRAMES - 1) begin
            cycle(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
            if (bus.fire_req === 1'b1) fires++;
        end
        pin("aim last frame", bus.phase, m_phase, 1);
        pin("aim last timer", bus.timer, m_timer, 0);
        cycle(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        pin("forfeit phase", bus.phase, m_phase, 3);
        chk("forfeit fire count", fires, 0);
        settle();
        pin("forfeit turn toggle", bus.turn, m_turn, 1);

        // Flight watchdog expires without damage
        cycle(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'h2C, 1'b0, 1'b0, 1'b0);
        repeat (FLIGHT_MAX - 1) cycle(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        pin("flight last frame", bus.phase, m_phase, 2);
        cycle(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        pin("watchdog phase", bus.phase, m_phase, 3);
        pin("watchdog HP_A",  bus.HP_A,  m_hpa,   10);
        pin("watchdog HP_B",  bus.HP_B,  m_hpb,   10);
        settle();

        // Reset mid-flight, late shot_done ignored
        cycle(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'h2C, 1'b0, 1'b0, 1'b0);
        repeat (5) cycle(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        pin("midflight reset phase", bus.phase,    m_phase, 0);
        pin("midflight reset turn",  bus.turn,     m_turn,  0);
        pin("midflight reset timer", bus.timer,    m_timer, 0);
        pin("midflight reset fire",  bus.fire_req, m_fire,  0);
        cycle(1'b1, 8'h00, 1'b1, 1'b1, 1'b1);
        pin("late shot HP_A",  bus.HP_A,  m_hpa,   10);
        pin("late shot phase", bus.phase, m_phase, 0);

        // Randomized play
        for (int i = 0; i < 20000; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 40)      rkey = 8'h00;
            else if (r < 52) rkey = 8'h2C;
            else if (r < 58) rkey = 8'h28;
            else if (r < 80) rkey = 8'h07;
            else             rkey = 8'($urandom_range(0, 255));
            cycle($urandom_range(0, 2999) != 0, rkey,
                  $urandom_range(0, 24) == 0,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        check_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
